vga_rx_timing: RTL and testbench
================================

// Module: vga_rx_timing
// PURPOSE
//  Receive side of the VGA driver interface. Samples an incoming hs/vs/RGB565 stream
//  (640x480@60, 25 MHz pixel clock), measures line and frame lengths, checks them against
//  the nominal timing, and recovers pixel_de / pixel_xpos / pixel_ypos / pixel_data for
//  capture or loop-back checking. Sits between the VGA pins (or a driver loop-back) and a
//  frame checker/writer.
// PARAMETERS
//  H_SYNC    96   hs low width (cycles); hs and vs are active-low
//  H_BACK    48   h back porch (cycles)
//  H_ACTIVE  640  active pixels per line
//  H_TOTAL   800  expected line length (cycles)
//  V_SYNC    2    vs low width (lines)
//  V_BACK    33   v back porch (lines)
//  V_ACTIVE  480  active lines per frame
//  V_TOTAL   525  expected frame length (lines)
//  LOCK_FRAMES 2  consecutive good frames required to assert locked
// PORTS
//  vga_clk       in   1   pixel clock, all logic on rising edge
//  sys_rst       in   1   synchronous reset, active-high
//  vga_hs        in   1   incoming horizontal sync, active-low
//  vga_vs        in   1   incoming vertical sync, active-low
//  vga_rgb       in   16  incoming pixel, RGB565
//  pixel_de      out  1   recovered active-video strobe (gated by locked)
//  pixel_xpos    out  10  column 0..639, valid when pixel_de
//  pixel_ypos    out  10  row 0..479, valid when pixel_de
//  pixel_data    out  16  pixel aligned to pixel_de/xpos/ypos
//  frame_start   out  1   1-cycle pulse coincident with pixel_de at (0,0)
//  locked        out  1   timing matches nominal for LOCK_FRAMES frames
//  h_total_meas  out  11  length of last complete line (cycles)
//  v_total_meas  out  10  length of last complete frame (lines)
// BEHAVIOUR
//  - Reset: all outputs 0; counters 0; seen_hs, seen_vs, good_frames, frame_err cleared.
//  - Stage 1: register vga_hs/vs/rgb (hs_d, vs_d, rgb_d). hs_fall = hs_d_prev&~hs_d;
//    vs_fall likewise. Stage 2: registered outputs. Pin->pixel_data latency = 2 cycles;
//    de/xpos/ypos are aligned to the same sample.
//  - h_cnt (11b): 0 on hs_fall cycle, else +1, saturating at 2047.
//  - On hs_fall with seen_hs=1: h_total_meas <= h_cnt+1; if !=H_TOTAL set frame_err and
//    drop locked in the same edge. First hs_fall after reset only sets seen_hs.
//  - v_cnt (10b): +1 on hs_fall, saturating at 1023; vs_fall forces 0 (wins if
//    simultaneous with hs_fall).
//  - On vs_fall with seen_vs=1: v_total_meas <= v_cnt+1. Good frame = (v_cnt+1==V_TOTAL)
//    and !frame_err -> good_frames+1 (saturate at LOCK_FRAMES); else good_frames<=0,
//    locked<=0. frame_err cleared on every vs_fall. First vs_fall only sets seen_vs
//    (partial frame after reset never counts).
//  - locked <= 1 when good_frames reaches LOCK_FRAMES at a vs_fall; drops at once on any
//    line error, bad frame, or h_cnt/v_cnt hitting saturation (sync lost).
//  - Active: h_cnt in [H_SYNC+H_BACK, +H_ACTIVE) and v_cnt in [V_SYNC+V_BACK, +V_ACTIVE).
//    pixel_de = active & locked; xpos = h_cnt-144, ypos = v_cnt-35 (defaults).
//    xpos/ypos/data hold 0 when pixel_de=0.
//  - frame_start = pixel_de & xpos==0 & ypos==0.
//  - Reset mid-frame: outputs 0 next cycle; relock needs one partial + LOCK_FRAMES frames.
// TESTING
//  1 Nominal 800x525 stream, rgb=xpos: locked rises at 3rd vs_fall after reset (1 partial
//    + 2 good); h_total_meas=800, v_total_meas=525.
//  2 Locked, rgb={ypos[5:0],xpos[9:0]}: pixel_data==f(xpos,ypos) for all 307200 de cycles;
//    frame_start once per frame at (0,0); pixel_de exactly 2 cycles after first active pin.
//  3 Inject one 799-cycle line mid-frame -> h_total_meas=799, locked=0 at that hs_fall,
//    pixel_de stays 0; relock after 2 further good frames.
//  4 Frame of 524 lines -> v_total_meas=524, locked=0 at that vs_fall, good_frames=0.
//  5 Hold hs high 2100 cycles -> h_cnt saturates at 2047, locked=0, no de.
//  6 Assert sys_rst mid-active line -> all outputs 0 next cycle; relock as in test 1.

Source files
------------

// File: rtl/vga_rx_timing.sv
// VGA receive timing: samples hs/vs/RGB565, measures line/frame lengths against nominal
// timing, and recovers de/xpos/ypos/data once the incoming stream is locked.
module vga_rx_timing #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [15:0] vga_rgb,
    output logic        pixel_de,
    output logic [9:0]  pixel_xpos,
    output logic [9:0]  pixel_ypos,
    output logic [15:0] pixel_data,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas
);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  V_LEN   = 10'(V_TOTAL);
    localparam int unsigned GF_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GF_W-1:0] GF_MAX = GF_W'(LOCK_FRAMES);

    logic            hs_d, vs_d, hs_d_prev, vs_d_prev;
    logic [15:0]     rgb_d;
    logic            hs_fall, vs_fall;
    logic [10:0]     h_cnt, h_next, h_len;
    logic [9:0]      v_cnt, v_next, v_len;
    logic            seen_hs, seen_vs, frame_err;
    logic [GF_W-1:0] good_frames, good_inc;
    logic            h_sat, v_sat, line_err, frame_ok, lock_next;
    logic            active, de_next;

    always_comb begin
        hs_fall = hs_d_prev & ~hs_d;
        vs_fall = vs_d_prev & ~vs_d;
        h_sat   = (h_cnt == '1);
        v_sat   = (v_cnt == '1);
        h_len   = h_cnt + 11'd1;
        v_len   = v_cnt + 10'd1;

        // The counters' next values are the raster position of the sample now held in rgb_d,
        // which keeps de/xpos/ypos aligned with the two-stage pixel path.
        h_next = hs_fall ? '0 : (h_sat ? h_cnt : h_len);
        v_next = v_cnt;
        if (vs_fall) begin
            v_next = '0;
        end else if (hs_fall && !v_sat) begin
            v_next = v_len;
        end

        line_err = hs_fall & seen_hs & (h_len != H_LEN);
        // A bad line ending on the same edge still belongs to the frame being judged.
        frame_ok = (v_len == V_LEN) & ~frame_err & ~line_err;
        good_inc = (good_frames >= GF_MAX) ? GF_MAX : good_frames + 1'b1;

        lock_next = locked;
        if (vs_fall && seen_vs) begin
            if (!frame_ok) begin
                lock_next = 1'b0;
            end else if (good_inc == GF_MAX) begin
                lock_next = 1'b1;
            end
        end
        if (line_err || h_sat || v_sat) begin
            lock_next = 1'b0;
        end

        active  = (h_next >= H_START) && (h_next < H_END) &&
                  (v_next >= V_START) && (v_next < V_END);
        de_next = active & locked;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hs_d         <= 1'b0;
            vs_d         <= 1'b0;
            hs_d_prev    <= 1'b0;
            vs_d_prev    <= 1'b0;
            rgb_d        <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            seen_hs      <= 1'b0;
            seen_vs      <= 1'b0;
            frame_err    <= 1'b0;
            good_frames  <= '0;
            locked       <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            pixel_de     <= 1'b0;
            pixel_xpos   <= '0;
            pixel_ypos   <= '0;
            pixel_data   <= '0;
            frame_start  <= 1'b0;
        end else begin
            hs_d      <= vga_hs;
            vs_d      <= vga_vs;
            hs_d_prev <= hs_d;
            vs_d_prev <= vs_d;
            rgb_d     <= vga_rgb;
            h_cnt     <= h_next;
            v_cnt     <= v_next;
            locked    <= lock_next;

            if (hs_fall) begin
                seen_hs <= 1'b1;
                if (seen_hs) begin
                    h_total_meas <= h_len;
                end
            end

            if (vs_fall) begin
                frame_err <= 1'b0;
            end else if (line_err || h_sat || v_sat) begin
                frame_err <= 1'b1;
            end

            if (vs_fall) begin
                seen_vs <= 1'b1;
                if (seen_vs) begin
                    v_total_meas <= v_len;
                    good_frames  <= frame_ok ? good_inc : '0;
                end
            end

            pixel_de    <= de_next;
            pixel_xpos  <= de_next ? 10'(h_next - H_START) : '0;
            pixel_ypos  <= de_next ? (v_next - V_START) : '0;
            pixel_data  <= de_next ? rgb_d : '0;
            frame_start <= de_next && (h_next == H_START) && (v_next == V_START);
        end
    end
endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing on a shrunken raster; every pixel-path output is
// scoreboarded against the generator's own raster position and known lock state.
module tb_vga_rx_timing;
    localparam int HS = 4, HB = 3, HA = 16, HT = 28;
    localparam int VS = 2, VB = 3, VA = 8, VT = 16;

    typedef struct packed {
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs;
    logic [15:0] rgb;
    logic        pixel_de, frame_start, locked;
    logic [9:0]  pixel_xpos, pixel_ypos, v_total_meas;
    logic [15:0] pixel_data;
    logic [10:0] h_total_meas;

    exp_t        q[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    vga_rx_timing #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(clk), .sys_rst(rst), .vga_hs(hs), .vga_vs(vs), .vga_rgb(rgb),
        .pixel_de(pixel_de), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .pixel_data(pixel_data), .frame_start(frame_start), .locked(locked),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    endtask

    // Outputs for a sample appear two edges after it is driven, so the scoreboard runs two deep.
    task automatic drive(input logic h, input logic v, input logic [15:0] d, input exp_t e);
        exp_t want, got;
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            want = q.pop_front();
            got  = '{de: pixel_de, x: pixel_xpos, y: pixel_ypos, d: pixel_data, fs: frame_start};
            check("pix", 64'(got), 64'(want));
        end
        hs  = h;
        vs  = v;
        rgb = d;
        q.push_back(e);
    endtask

    task automatic send_line(input int len, input int vline, input logic lk);
        logic        act;
        logic [9:0]  xv, yv;
        logic [15:0] d;
        exp_t        e;
        for (int p = 0; p < len; p++) begin
            act = (p >= HS + HB) && (p < HS + HB + HA) && (vline >= VS + VB) && (vline < VS + VB + VA);
            xv  = 10'(p - (HS + HB));
            yv  = 10'(vline - (VS + VB));
            d   = act ? {yv[5:0], xv} : 16'($urandom);
            e.de = act & lk;
            e.x  = e.de ? xv : '0;
            e.y  = e.de ? yv : '0;
            e.d  = e.de ? d : '0;
            e.fs = e.de && (xv == 10'd0) && (yv == 10'd0);
            drive(p >= HS, vline >= VS, d, e);
        end
    endtask

    task automatic send_frame(input int nl, input logic lk);
        for (int l = 0; l < nl; l++) send_line(HT, l, lk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 16'($urandom), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hs  = 1'b1;
        vs  = 1'b1;
        rgb = '0;
        @(posedge clk);
        #1;
        check("rst_de", 64'(pixel_de), 64'(0));
        check("rst_x", 64'(pixel_xpos), 64'(0));
        check("rst_y", 64'(pixel_ypos), 64'(0));
        check("rst_data", 64'(pixel_data), 64'(0));
        check("rst_fs", 64'(frame_start), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_hmeas", 64'(h_total_meas), 64'(0));
        check("rst_vmeas", 64'(v_total_meas), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic partial_then_lock();
        idle(3);
        for (int l = 10; l < VT; l++) send_line(HT, l, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; rgb = '0;
        do_reset();

        // Nominal stream: one partial frame plus two good frames before lock.
        partial_then_lock();
        send_frame(VT, 1'b1);
        check("t1_locked", 64'(locked), 64'(1));
        check("t1_hmeas", 64'(h_total_meas), 64'(HT));
        check("t1_vmeas", 64'(v_total_meas), 64'(VT));
        send_frame(VT, 1'b1);

        // One short line in the active area.
        for (int l = 0; l < 7; l++) send_line(HT, l, 1'b1);
        send_line(HT - 1, 7, 1'b1);
        send_line(HT, 8, 1'b0);
        check("t3_hmeas", 64'(h_total_meas), 64'(HT - 1));
        check("t3_locked", 64'(locked), 64'(0));
        for (int l = 9; l < VT; l++) send_line(HT, l, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b1);
        check("t3_relock", 64'(locked), 64'(1));

        // Short frame.
        send_frame(VT - 1, 1'b1);
        send_line(HT, 0, 1'b0);
        check("t4_vmeas", 64'(v_total_meas), 64'(VT - 1));
        check("t4_locked", 64'(locked), 64'(0));
        for (int l = 1; l < VT; l++) send_line(HT, l, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b1);
        check("t4_relock", 64'(locked), 64'(1));

        // Sync lost: hs held high long enough to saturate the line counter.
        idle(2100);
        check("t5_locked", 64'(locked), 64'(0));
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b1);
        check("t5_relock", 64'(locked), 64'(1));

        // Reset in the middle of an active line, then relock from scratch.
        for (int l = 0; l < 7; l++) send_line(HT, l, 1'b1);
        send_line(12, 7, 1'b1);
        do_reset();
        partial_then_lock();
        send_frame(VT, 1'b1);
        check("t6_locked", 64'(locked), 64'(1));
        check("t6_hmeas", 64'(h_total_meas), 64'(HT));
        check("t6_vmeas", 64'(v_total_meas), 64'(VT));
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
